// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential MIPS mult/multu controller.
package alu_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Request/result bundle between the ALU control (master) and the multiplier (slave).
interface alu_mult_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) ();

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_abs.sv
// Conditional two's-complement magnitude; the most-negative value maps to itself
// and is then read as an unsigned magnitude by the multiplier.
module mult_abs
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  logic             en,
  output logic [WIDTH-1:0] mag
);

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  // negate only when signed interpretation is requested and the value is negative
  always_comb begin
    if (en && val[WIDTH-1]) begin
      mag = ~val + ONE_W;
    end else begin
      mag = val;
    end
  end

endmodule

// File: rtl/alu_mult_seq.sv
// Multi-cycle 32x32 shift-add multiplier producing a 64-bit HI/LO product.
// Optional zero-operand shortcut: MULT_ZERO_BYPASS_EN.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mult_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  mult_state_t        state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH:0]   prod_r;
  logic [WIDTH-1:0]   mcand_r;
  logic               neg_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic               accept_s, zero_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH:0]   step_s;
  logic [2*WIDTH-1:0] res_s;

  mult_abs #(.WIDTH(WIDTH)) u_abs_a (.val(bus.a), .en(bus.signed_op), .mag(mag_a_s));
  mult_abs #(.WIDTH(WIDTH)) u_abs_b (.val(bus.b), .en(bus.signed_op), .mag(mag_b_s));

  assign accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_s = (bus.a == {WIDTH{1'b0}}) || (bus.b == {WIDTH{1'b0}});
`else
  assign zero_s = 1'b0;
`endif

  // one shift-add step; the carry lands in P[2W] before the right shift
  always_comb begin
    sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    if (prod_r[0]) begin
      step_s = {sum_s, prod_r[WIDTH-1:0]};
    end else begin
      step_s = prod_r;
    end
    if (neg_r) begin
      res_s = ~prod_r[2*WIDTH-1:0] + ONE_P;
    end else begin
      res_s = prod_r[2*WIDTH-1:0];
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          if (zero_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // state register and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CALC) || (state_s == FIX);
      done_r  <= (state_s == DONE);
    end
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      prod_r  <= {(2*WIDTH+1){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        mcand_r <= mag_a_s;
        prod_r  <= {{(WIDTH+1){1'b0}}, mag_b_s};
        neg_r   <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        cnt_r   <= {CNT_W{1'b0}};
        if (zero_s) begin
          hi_r <= {WIDTH{1'b0}};
          lo_r <= {WIDTH{1'b0}};
        end
      end else if (state_r == CALC) begin
        prod_r <= step_s >> 1;
        cnt_r  <= cnt_r + CNT_ONE;
      end else if (state_r == FIX) begin
        {hi_r, lo_r} <= res_s;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed self-checking bench for alu_mult_seq: vector table plus multi-cycle corner sequences.
module tb_alu_mult_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mult_seq_if #(.WIDTH(32)) bus ();
  alu_mult_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    string       name;
    logic        so;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic so, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = so; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count cycles to done (1 = negedge right after accept) and busy cycles; track that hi/lo hold.
  task automatic wait_done(input logic [63:0] hold, output int lat, output int bcnt, output logic held);
    lat = 1; bcnt = 0; held = 1'b1;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      if ({bus.hi, bus.lo} !== hold) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat, bcnt;
    logic held;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = 32'd0; bus.b = 32'd0;

    vecs[0] = '{"multu_7x6",      1'b0, 32'd7,        32'd6,        64'h0000_0000_0000_002A};
    vecs[1] = '{"mult_m3x5",      1'b1, 32'hFFFF_FFFD, 32'd5,       64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{"multu_max",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{"mult_min_min",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{"mult_min_x1",    1'b1, 32'h8000_0000, 32'd1,       64'hFFFF_FFFF_8000_0000};
    vecs[5] = '{"mult_m1xm1",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[6] = '{"mult_maxpos_m1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
    vecs[7] = '{"multu_shift",    1'b0, 32'h1234_5678, 32'h10,      64'h0000_0001_2345_6780};
    vecs[8] = '{"multu_min_min",  1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[9] = '{"multu_max_x2",   1'b0, 32'hFFFF_FFFF, 32'd2,       64'h0000_0001_FFFF_FFFE};

    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].so, vecs[i].a, vecs[i].b);
      wait_done(64'd0, lat, bcnt, held);
      check({vecs[i].name, "_hilo"}, {bus.hi, bus.lo}, vecs[i].prod);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd34);
      check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'd33);
      check({vecs[i].name, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    end

    // zero operand with a non-zero previous result in hi/lo
    issue(1'b0, 32'd0, 32'd5);
    wait_done(64'd0, lat, bcnt, held);
    check("zero_hilo", {bus.hi, bus.lo}, 64'd0);
`ifdef MULT_ZERO_BYPASS_EN
    check("zero_latency", 64'(lat), 64'd1);
    check("zero_busy_cycles", 64'(bcnt), 64'd0);
`else
    check("zero_latency", 64'(lat), 64'd34);
    check("zero_busy_cycles", 64'(bcnt), 64'd33);
`endif
    @(negedge clk);

    // start while busy is ignored
    issue(1'b0, 32'd7, 32'd6);
    lat = 1; bcnt = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      if (lat == 10) begin
        bus.start = 1'b1; bus.signed_op = 1'b1; bus.a = 32'd100; bus.b = 32'd100;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("ignore_hilo", {bus.hi, bus.lo}, 64'h2A);
    check("ignore_latency", 64'(lat), 64'd34);
    check("ignore_busy_cycles", 64'(bcnt), 64'd33);

    // back-to-back start in the DONE cycle
    bus.start = 1'b1; bus.signed_op = 1'b1; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_done_drops", {63'd0, bus.done}, 64'd0);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(64'h2A, lat, bcnt, held);
    check("b2b_hold_first", {63'd0, held}, 64'd1);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    @(negedge clk);

    // asynchronous reset mid-operation
    issue(1'b0, 32'h1234, 32'h10);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd3, 32'd3);
    wait_done(64'd0, lat, bcnt, held);
    check("after_reset_hilo", {bus.hi, bus.lo}, 64'd9);
    check("after_reset_latency", 64'(lat), 64'd34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle 32x32 shift-add multiplier controller that sequences the ALU's 32-bit add datapath to produce a 64-bit HI/LO product for MIPS mult/multu.
- Sits beside the combinational ALU; the ALU control asserts start and stalls until done.
- Handles signed operands by magnitude conversion followed by a final conditional negate.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- signed_op  input  1  1 = mult (two's complement), 0 = multu
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse, high in DONE
- hi  output  WIDTH  upper product half
- lo  output  WIDTH  lower product half

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, on rst_n.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers 0. Assertion mid-operation aborts immediately; no partial result reaches hi/lo.
- States and transitions:
  - IDLE: start=1 goes to CALC.
  - CALC: runs exactly WIDTH cycles, then goes to FIX.
  - FIX: 1 cycle, then goes to DONE.
  - DONE: 1 cycle; start=1 goes to CALC (back-to-back), otherwise goes to IDLE.
- Capture on the accepting edge:
  - mcand = |a| if signed_op, else a.
  - P = {WIDTH+1 zeros, |b| or b} (2*WIDTH+1 bits).
  - neg = signed_op & (a[MSB]^b[MSB]).
  - cnt = 0.
- Magnitude of the most-negative operand (0x80000000) is 0x80000000 interpreted unsigned; the arithmetic must handle it.
- CALC iteration:
  - If P[0], P[2W:W] = P[2W-1:W] + mcand, a (W+1)-bit sum keeping the carry.
  - Then P shifts right logically by 1.
  - cnt increments; leave CALC when cnt == WIDTH-1 at the clock edge.
- FIX: result R = neg ? (~P[2W-1:0] + 1) : P[2W-1:0], a 64-bit two's-complement negate.
- Output update: on the FIX->DONE edge, {hi,lo} = R. hi/lo hold until the next result or reset.
- Latency: start sampled at edge E0; done high between E(W+1) and E(W+2), i.e. 34 cycles for WIDTH=32.
- busy=1 from E0 to E(W+1); busy=0 in DONE.
- start while busy: ignored, no queueing. a, b and signed_op changes while busy have no effect.
- Simultaneous start in DONE: done still pulses that cycle; the new operation begins; hi/lo keep the previous result until its own FIX->DONE edge.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined: on the accepting edge, if a==0 or b==0, go directly to DONE and load hi=lo=0 on that edge; done is high one cycle after start, and busy never asserts.
- Undefined: zero operands take the full WIDTH+2 cycle path and produce 0.

Decomposition:
- Package alu_pkg:
  - state enum mult_state_t {IDLE, CALC, FIX, DONE}.
  - localparam MULT_WIDTH=32.
- One sub-module, mult_abs: combinational WIDTH-bit conditional two's-complement magnitude (input, sign-enable, output). Instantiate it twice, for a and b.
- The FSM, counter, adder and final negate stay in alu_mult_seq.

Test Plan:
- Unsigned multiply: multu a=7, b=6 -> done at cycle 34, hi=0x00000000, lo=0x0000002A, busy high for exactly 33 cycles.
- Signed negative result: mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned maximum operands: multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed most-negative operands: mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; and mult a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Start ignored while busy, then back-to-back: start again at cycle 10 with new operands -> ignored, first result unchanged. Start asserted in the DONE cycle -> second op accepted; hi/lo hold the first result until the second done.
- Reset mid-operation and zero bypass:
  - rst_n low at cycle 15 -> busy=0, done=0, hi=lo=0 immediately. After release, 3*3 -> lo=9.
  - With MULT_ZERO_BYPASS_EN defined, a=0 -> done one cycle after start, busy never asserts.
